// File: rtl/tri_bus_arb_if.sv
// Shared tristate-bus arbitration bundle: requester
// strobes in, registered drive enables and owner status out.
interface tri_bus_arb_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] en;
    logic [W-1:0] gnt_id;
    logic         busy;

    modport master (
        output req,
        output done,
        input  en,
        input  gnt_id,
        input  busy
    );

    modport slave (
        input  req,
        input  done,
        output en,
        output gnt_id,
        output busy
    );
endinterface

// File: rtl/tri_bus_arb.sv
// Round-robin owner arbiter for a shared tristate bus with
// bounded bursts and an enforced idle turnaround between owners.
module tri_bus_arb #(
    parameter int N    = 4,
    parameter int MAXB = 8,
    parameter int TURN = 1
) (
    input  logic         clk,
    input  logic         rst,
    tri_bus_arb_if.slave bus
);
    localparam int W = $clog2(N);
    localparam logic [7:0] MAXB_C = 8'(MAXB);
    localparam logic [3:0] TURN_C = 4'(TURN);
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURNAROUND
    } state_t;

    state_t       state;
    logic [7:0]   burst;
    logic [3:0]   tcnt;
    logic [W-1:0] last;

    logic [W-1:0] win;
    logic [W-1:0] idx;
    logic         found;
    logic         any_req;
    logic         rel;

    // Search starts just past the previous owner so it ranks last.
    always_comb begin
        win   = last;
        idx   = last;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(last) + i) % N);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign any_req = |bus.req;
    assign rel = !bus.req[bus.gnt_id]
               || bus.done[bus.gnt_id]
               || (burst == MAXB_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus.en     <= '0;
            bus.busy   <= 1'b0;
            bus.gnt_id <= '0;
            burst      <= '0;
            tcnt       <= '0;
            last       <= W'(N - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= GRANT;
                        bus.en     <= ONE << win;
                        bus.busy   <= 1'b1;
                        bus.gnt_id <= win;
                        last       <= win;
                        burst      <= 8'd1;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        state    <= TURNAROUND;
                        bus.en   <= '0;
                        bus.busy <= 1'b0;
                        burst    <= '0;
                        tcnt     <= 4'd1;
                    end else begin
                        burst <= burst + 8'd1;
                    end
                end
                TURNAROUND: begin
                    if (tcnt == TURN_C) begin
                        tcnt <= '0;
                        if (any_req) begin
                            state      <= GRANT;
                            bus.en     <= ONE << win;
                            bus.busy   <= 1'b1;
                            bus.gnt_id <= win;
                            last       <= win;
                            burst      <= 8'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tcnt <= tcnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tri_bus_arb.sv
// Directed bench for tri_bus_arb: TURN=1 and TURN=3 instances
// with hand-computed enable sequences and bus invariants.
module tb_tri_bus_arb;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    tri_bus_arb_if #(.N(4)) a ();
    tri_bus_arb_if #(.N(4)) b ();

    tri_bus_arb #(.N(4), .MAXB(8), .TURN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    tri_bus_arb #(.N(4), .MAXB(8), .TURN(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_a(input string tag, input int n,
                          input logic [3:0] exp);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, 8'(a.en), 8'(exp));
        end
    endtask

    task automatic hold_b(input string tag, input int n,
                          input logic [3:0] exp);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, 8'(b.en), 8'(exp));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        chk("rst_en", 8'(a.en), 8'h0);
        chk("rst_busy", 8'(a.busy), 8'h0);
        chk("rst_gnt", 8'(a.gnt_id), 8'h0);
        chk("rst_en3", 8'(b.en), 8'h0);
        rst = 1'b0;
    endtask

    // Bus invariants on both instances every cycle
    always @(negedge clk) begin
        checks++;
        assert ($onehot0(a.en) === 1'b1) else begin
            errors++;
            $error("FAIL onehot_a: got %b want onehot0", a.en);
        end
        checks++;
        assert (a.busy === (a.en != 4'b0)) else begin
            errors++;
            $error("FAIL busy_a: got %b want %b", a.busy, a.en != 4'b0);
        end
        if (a.busy) begin
            checks++;
            assert (a.en === (4'b1 << a.gnt_id)) else begin
                errors++;
                $error("FAIL id_a: got %b want %b", a.en, 4'b1 << a.gnt_id);
            end
        end
        checks++;
        assert ($onehot0(b.en) === 1'b1) else begin
            errors++;
            $error("FAIL onehot_b: got %b want onehot0", b.en);
        end
        checks++;
        assert (b.busy === (b.en != 4'b0)) else begin
            errors++;
            $error("FAIL busy_b: got %b want %b", b.busy, b.en != 4'b0);
        end
    end

    initial begin
        rst    = 1'b1;
        a.req  = '0;
        a.done = '0;
        b.req  = '0;
        b.done = '0;

        // Sole requester: 8-cycle burst, one idle, re-grant
        do_reset();
        a.req = 4'b0001;
        hold_a("solo_burst", 8, 4'b0001);
        chk("solo_gnt", 8'(a.gnt_id), 8'h0);
        hold_a("solo_gap", 1, 4'b0000);
        hold_a("solo_regrant", 2, 4'b0001);

        // All requesting through reset release: full rotation
        a.req = 4'b1111;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            hold_a("rr_burst", 8, 4'(1 << (k % 4)));
            hold_a("rr_gap", 1, 4'b0000);
        end

        // Owner 2 early done, next is 3; non-owner done ignored
        a.req = 4'b0000;
        do_reset();
        a.req = 4'b0100;
        hold_a("o2_grant", 1, 4'b0100);
        chk("o2_gnt", 8'(a.gnt_id), 8'h2);
        a.req = 4'b1101;
        hold_a("o2_hold", 2, 4'b0100);
        a.done = 4'b0100;
        hold_a("o2_done", 1, 4'b0000);
        chk("o2_busy", 8'(a.busy), 8'h0);
        a.done = 4'b0000;
        hold_a("o3_grant", 1, 4'b1000);
        chk("o3_gnt", 8'(a.gnt_id), 8'h3);
        a.done = 4'b0001;
        hold_a("nonowner_done", 1, 4'b1000);
        a.done = 4'b0000;
        a.req  = 4'b0001;
        hold_a("o3_drop", 1, 4'b0000);
        hold_a("o0_after3", 1, 4'b0001);

        // Simultaneous drop and done: single release, then 0
        a.req = 4'b0000;
        do_reset();
        a.req = 4'b0100;
        hold_a("sim_grant", 1, 4'b0100);
        a.req = 4'b0101;
        hold_a("sim_hold", 1, 4'b0100);
        a.req  = 4'b0001;
        a.done = 4'b0100;
        hold_a("sim_rel", 1, 4'b0000);
        a.done = 4'b0000;
        hold_a("sim_next0", 1, 4'b0001);
        chk("sim_gnt0", 8'(a.gnt_id), 8'h0);

        // Reset mid-GRANT restores pointer
        a.req = 4'b0000;
        do_reset();
        a.req = 4'b0010;
        hold_a("mid_grant", 4, 4'b0010);
        rst = 1'b1;
        step();
        chk("mid_rst_en", 8'(a.en), 8'h0);
        chk("mid_rst_busy", 8'(a.busy), 8'h0);
        rst = 1'b0;
        a.req = 4'b0011;
        hold_a("mid_ptr", 1, 4'b0001);

        // TURN=3: three idle cycles between owners, then idle
        a.req = 4'b0000;
        do_reset();
        b.req = 4'b0010;
        hold_b("t3_grant1", 1, 4'b0010);
        b.req = 4'b0100;
        hold_b("t3_gap", 3, 4'b0000);
        hold_b("t3_grant2", 1, 4'b0100);
        chk("t3_gnt2", 8'(b.gnt_id), 8'h2);
        b.req = 4'b0000;
        hold_b("t3_idle", 5, 4'b0000);
        b.req = 4'b0001;
        hold_b("t3_from_idle", 1, 4'b0001);
        b.req = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
